// File: rtl/cohort_noc1_req_queue.sv
// ---------------------------------------------------------------------------
// cohort_noc1_req_queue
//
// In-order request buffer between the cohort engine's noc1buffer_* outputs
// and the DCP NoC1 encoder. It absorbs encoder backpressure in a small FIFO
// and limits the number of requests in flight with an issue-credit counter.
// Each NoC2 response valid returns one credit.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_val / in_rdy     request handshake from the cohort engine
//   in_*                request payload (type, mshrid, address, size,
//                       two data words, AMO write mask)
//   out_val / out_rdy   request handshake toward the NoC1 encoder
//   out_*               payload of the head entry
//   resp_val            one NoC2 response returned (one credit back)
//   occupancy           number of entries held
//   credits             issue credits currently available
//   credit_err          sticky: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module cohort_noc1_req_queue #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TYPE_W          = 8,
    parameter int MSHRID_W        = 8,
    parameter int PADDR_W         = 40,
    parameter int MASK_W          = 8
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic [TYPE_W-1:0]          in_type,
    input  logic [MSHRID_W-1:0]        in_mshrid,
    input  logic [PADDR_W-1:0]         in_address,
    input  logic [2:0]                 in_size,
    input  logic [63:0]                in_data_0,
    input  logic [63:0]                in_data_1,
    input  logic [MASK_W-1:0]          in_write_mask,

    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [TYPE_W-1:0]          out_type,
    output logic [MSHRID_W-1:0]        out_mshrid,
    output logic [PADDR_W-1:0]         out_address,
    output logic [2:0]                 out_size,
    output logic [63:0]                out_data_0,
    output logic [63:0]                out_data_1,
    output logic [MASK_W-1:0]          out_write_mask,

    input  logic                       resp_val,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [3:0]                 credits,
    output logic                       credit_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PL_W  = TYPE_W + MSHRID_W + PADDR_W + 3 + 64 + 64 + MASK_W;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [3:0]       MAX_CRED = 4'(MAX_OUTSTANDING);

    // Payload storage is datapath only and carries no reset.
    logic [PL_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]       credits_q, credits_d;
    logic             credit_err_q, credit_err_d;

    logic             enq;
    logic             deq;
    logic [PL_W-1:0]  in_payload;
    logic [PL_W-1:0]  head_payload;

    assign in_payload = {in_type, in_mshrid, in_address, in_size,
                         in_data_0, in_data_1, in_write_mask};
    assign head_payload = mem_q[rd_ptr_q];

    // in_rdy looks only at the registered count, never at out_rdy, so a
    // full queue does not accept even when the head is leaving this cycle.
    assign in_rdy  = !rst && (count_q < DEPTH_C);
    assign out_val = (count_q != '0) && (credits_q != 4'd0);

    assign enq = in_val && in_rdy;
    assign deq = out_val && out_rdy;

    assign {out_type, out_mshrid, out_address, out_size,
            out_data_0, out_data_1, out_write_mask} = head_payload;

    assign occupancy  = count_q;
    assign credits    = credits_q;
    assign credit_err = credit_err_q;

    always_comb begin
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;

        // Pointers wrap by natural overflow (DEPTH is a power of two).
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // An issue and a response in the same cycle cancel out. A response
        // with every credit already home is an accounting error: hold the
        // counter and flag it until the next reset.
        if (deq && !resp_val) begin
            credits_d = credits_q - 4'd1;
        end else if (resp_val && !deq) begin
            if (credits_q == MAX_CRED) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            credits_q    <= MAX_CRED;
            credit_err_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    // enq already excludes reset, so no write lands while rst is high.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= in_payload;
        end
    end

endmodule
